// File: rtl/acc_nonce_target_checker.sv
// Nonce/target checker: the stage after the SHA-256 accelerator.
// Each finished digest is byte-reversed and compared against the latched
// difficulty target. A miss steps the nonce and asks upstream for the next
// digest. A hit, or a miss on the last allowed nonce, writes a result record
// to data memory through the write handshake and then pulses done.
module acc_nonce_target_checker #(
    parameter logic [31:0] NONCE_MAX        = 32'hFFFF_FFFF,
    parameter logic [15:0] RESULT_BASE_ADDR = 16'h0100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  nonce_start,
    input  logic [255:0] target,
    input  logic         hash_valid,
    input  logic [255:0] hash,
    output logic [31:0]  nonce_out,
    output logic         next_req,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         done,
    output logic         mem_acc_write_en,
    output logic [15:0]  mem_acc_write_addr,
    output logic [31:0]  mem_acc_write_data,
    input  logic         mem_acc_write_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HASH = 3'd1,
        CMP       = 3'd2,
        WRITE     = 3'd3,
        FIN       = 3'd4
    } state_t;

    // Index of the last word in each record type.
    localparam logic [3:0] LAST_IDX_HIT = 4'd9;
    localparam logic [3:0] LAST_IDX_EXH = 4'd1;

    state_t         state_r, state_s;
    logic [255:0]   target_r, target_s;
    logic [255:0]   hash_r, hash_s;
    logic [3:0]     word_idx_r, word_idx_s;
    logic [3:0]     last_idx_r, last_idx_s;
    logic           hit_s;

    logic [31:0]    nonce_s;
    logic           next_req_s;
    logic           busy_s;
    logic           found_s;
    logic           exhausted_s;
    logic           done_s;
    logic           wen_s;
    logic [15:0]    waddr_s;
    logic [31:0]    wdata_s;

    // Digest byte 0 (bits [7:0]) becomes the most significant byte.
    function automatic logic [255:0] byte_rev(input logic [255:0] h);
        logic [255:0] r;
        r = 256'h0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = h[255-8*i -: 8];
        end
        return r;
    endfunction

    // Result record word k: status, nonce, then digest words H0..H7.
    function automatic logic [31:0] word_sel(
        input logic [3:0]   k,
        input logic [1:0]   status,
        input logic [31:0]  nonce,
        input logic [255:0] h
    );
        logic [31:0] w;
        case (k)
            4'd0:    w = {30'b0, status};
            4'd1:    w = nonce;
            4'd2:    w = h[255:224];
            4'd3:    w = h[223:192];
            4'd4:    w = h[191:160];
            4'd5:    w = h[159:128];
            4'd6:    w = h[127:96];
            4'd7:    w = h[95:64];
            4'd8:    w = h[63:32];
            4'd9:    w = h[31:0];
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Full-width unsigned compare of the reordered digest against the target.
    always_comb begin
        hit_s = (byte_rev(hash_r) <= target_r);
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s     = state_r;
        target_s    = target_r;
        hash_s      = hash_r;
        word_idx_s  = word_idx_r;
        last_idx_s  = last_idx_r;
        nonce_s     = nonce_out;
        next_req_s  = 1'b0;
        found_s     = found;
        exhausted_s = exhausted;
        done_s      = 1'b0;
        wen_s       = mem_acc_write_en;
        waddr_s     = mem_acc_write_addr;
        wdata_s     = mem_acc_write_data;

        case (state_r)
            IDLE: begin
                if (start) begin
                    target_s    = target;
                    nonce_s     = nonce_start;
                    found_s     = 1'b0;
                    exhausted_s = 1'b0;
                    next_req_s  = 1'b1;
                    state_s     = WAIT_HASH;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_HASH: begin
                if (hash_valid) begin
                    hash_s  = hash;
                    state_s = CMP;
                end else begin
                    state_s = WAIT_HASH;
                end
            end
            CMP: begin
                if (hit_s) begin
                    found_s    = 1'b1;
                    last_idx_s = LAST_IDX_HIT;
                    word_idx_s = 4'd0;
                    wen_s      = 1'b1;
                    waddr_s    = RESULT_BASE_ADDR;
                    wdata_s    = word_sel(4'd0, {exhausted_s, found_s}, nonce_s, hash_r);
                    state_s    = WRITE;
                end else if (nonce_out == NONCE_MAX) begin
                    exhausted_s = 1'b1;
                    last_idx_s  = LAST_IDX_EXH;
                    word_idx_s  = 4'd0;
                    wen_s       = 1'b1;
                    waddr_s     = RESULT_BASE_ADDR;
                    wdata_s     = word_sel(4'd0, {exhausted_s, found_s}, nonce_s, hash_r);
                    state_s     = WRITE;
                end else begin
                    nonce_s    = nonce_out + 32'd1;
                    next_req_s = 1'b1;
                    state_s    = WAIT_HASH;
                end
            end
            WRITE: begin
                if (mem_acc_write_en) begin
                    if (mem_acc_write_done) begin
                        wen_s = 1'b0;
                        if (word_idx_r == last_idx_r) begin
                            done_s  = 1'b1;
                            state_s = FIN;
                        end else begin
                            word_idx_s = word_idx_r + 4'd1;
                        end
                    end else begin
                        wen_s = 1'b1;
                    end
                end else begin
                    // One idle cycle after each accepted word, then present the next.
                    wen_s   = 1'b1;
                    waddr_s = RESULT_BASE_ADDR + {12'h000, word_idx_r};
                    wdata_s = word_sel(word_idx_r, {exhausted, found}, nonce_out, hash_r);
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and registered outputs; synchronous reset abandons any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= IDLE;
            target_r           <= 256'h0;
            hash_r             <= 256'h0;
            word_idx_r         <= 4'd0;
            last_idx_r         <= 4'd0;
            nonce_out          <= 32'h0;
            next_req           <= 1'b0;
            busy               <= 1'b0;
            found              <= 1'b0;
            exhausted          <= 1'b0;
            done               <= 1'b0;
            mem_acc_write_en   <= 1'b0;
            mem_acc_write_addr <= 16'h0;
            mem_acc_write_data <= 32'h0;
        end else begin
            state_r            <= state_s;
            target_r           <= target_s;
            hash_r             <= hash_s;
            word_idx_r         <= word_idx_s;
            last_idx_r         <= last_idx_s;
            nonce_out          <= nonce_s;
            next_req           <= next_req_s;
            busy               <= busy_s;
            found              <= found_s;
            exhausted          <= exhausted_s;
            done               <= done_s;
            mem_acc_write_en   <= wen_s;
            mem_acc_write_addr <= waddr_s;
            mem_acc_write_data <= wdata_s;
        end
    end

endmodule

// File: tb/tb_acc_nonce_target_checker.sv
// Testbench for acc_nonce_target_checker: table-driven jobs, hand-written
// reset/abuse sequences and randomized jobs checked against a reference model.
module tb_acc_nonce_target_checker;

    localparam logic [31:0] NONCE_MAX = 32'hFFFF_FFFF;
    localparam logic [15:0] BASE      = 16'h0100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  nonce_start = 32'h0;
    logic [255:0] target = 256'h0;
    logic         hash_valid = 1'b0;
    logic [255:0] hash = 256'h0;
    logic [31:0]  nonce_out;
    logic         next_req;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         done;
    logic         mem_acc_write_en;
    logic [15:0]  mem_acc_write_addr;
    logic [31:0]  mem_acc_write_data;
    logic         mem_acc_write_done = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [255:0] hq[$];

    acc_nonce_target_checker #(
        .NONCE_MAX(NONCE_MAX),
        .RESULT_BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .nonce_start(nonce_start),
        .target(target),
        .hash_valid(hash_valid),
        .hash(hash),
        .nonce_out(nonce_out),
        .next_req(next_req),
        .busy(busy),
        .found(found),
        .exhausted(exhausted),
        .done(done),
        .mem_acc_write_en(mem_acc_write_en),
        .mem_acc_write_addr(mem_acc_write_addr),
        .mem_acc_write_data(mem_acc_write_data),
        .mem_acc_write_done(mem_acc_write_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: the digest read as a little-endian 256-bit number.
    function automatic logic [255:0] rev(input logic [255:0] h);
        logic [255:0] r;
        r = {<<8{h}};
        return r;
    endfunction

    function automatic bit model_hit(input logic [255:0] h, input logic [255:0] t);
        return rev(h) <= t;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one job over the digests in hq. abort_at >= 0 pulses rst while
    // that record word is on the bus.
    task automatic run_job(input logic [31:0] ns, input logic [255:0] tgt,
                           input int wd_delay, input bit hold, input bit gap_abuse,
                           input int abort_at);
        logic [31:0]  cur;
        logic [255:0] last_h;
        logic [31:0]  exp_w[10];
        bit           f_found;
        bit           f_exh;
        bit           stable;
        int           len;
        start = 1'b1; nonce_start = ns; target = tgt;
        tick();
        start = 1'b0; nonce_start = $urandom; target = rnd256();
        chk("start_next_req", next_req, 1);
        chk("start_nonce", nonce_out, ns);
        chk("start_busy", busy, 1);
        chk("start_found_clr", {found, exhausted}, 0);
        cur = ns; f_found = 1'b0; f_exh = 1'b0; last_h = 256'h0;
        mem_acc_write_done = hold;
        foreach (hq[i]) begin
            int w;
            w = $urandom_range(0, 2);
            for (int c = 0; c < w; c++) begin
                if (c == 0) begin
                    start = 1'b1; nonce_start = ~ns; target = 256'h0;
                end
                tick();
                start = 1'b0;
            end
            hash_valid = 1'b1; hash = hq[i];
            tick();
            hash_valid = 1'b0; hash = rnd256();
            chk("cmp_quiet", {next_req, mem_acc_write_en}, 0);
            tick();
            if (model_hit(hq[i], tgt)) begin
                f_found = 1'b1; last_h = hq[i];
                chk("hit_wen_t2", mem_acc_write_en, 1);
                break;
            end else if (cur == NONCE_MAX) begin
                f_exh = 1'b1;
                chk("exh_wen_t2", {mem_acc_write_en, next_req}, 2);
                break;
            end else begin
                cur = cur + 32'd1;
                chk("miss_next_req_t2", next_req, 1);
                chk("miss_nonce", nonce_out, cur);
            end
        end
        if (!f_found && !f_exh) begin
            n_chk++; n_fail++;
            $display("FAIL job_unterminated: got no end after %0d digests required hit or exhaustion", hq.size());
            mem_acc_write_done = 1'b0;
            return;
        end
        len = f_found ? 10 : 2;
        exp_w[0] = {30'b0, f_exh, f_found};
        exp_w[1] = cur;
        for (int j = 0; j < 8; j++) exp_w[2+j] = 32'(last_h >> (32*(7-j)));
        for (int k = 0; k < len; k++) begin
            if (k > 0) begin
                chk("gap_low", mem_acc_write_en, 0);
                if (gap_abuse && !hold) mem_acc_write_done = 1'b1;
                tick();
                mem_acc_write_done = hold;
                chk("word_rise", mem_acc_write_en, 1);
            end
            chk("addr", mem_acc_write_addr, BASE + 16'(k));
            chk("data", mem_acc_write_data, exp_w[k]);
            if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                mem_acc_write_done = 1'b0;
                chk("rst_mid_write", {mem_acc_write_en, busy, found, done}, 0);
                chk("rst_nonce", nonce_out, 0);
                return;
            end
            stable = 1'b1;
            for (int d = 0; d < wd_delay; d++) begin
                if (d == 0) begin
                    hash_valid = 1'b1; hash = 256'h0;
                end
                tick();
                hash_valid = 1'b0;
                if (mem_acc_write_en !== 1'b1 || mem_acc_write_addr !== BASE + 16'(k) ||
                    mem_acc_write_data !== exp_w[k]) stable = 1'b0;
            end
            if (wd_delay > 0) chk("word_stable", stable, 1);
            mem_acc_write_done = 1'b1;
            tick();
            mem_acc_write_done = hold;
        end
        chk("fin_done", {done, mem_acc_write_en, busy}, 3'b101);
        mem_acc_write_done = 1'b0;
        tick();
        chk("after_fin", {done, busy}, 0);
        chk("final_flags", {found, exhausted}, {f_found, f_exh});
        chk("final_nonce", nonce_out, cur);
    endtask

    typedef struct {
        logic [31:0]  ns;
        logic [255:0] tgt;
        logic [255:0] h0;
        logic [255:0] h1;
        int           nh;
        int           dly;
        bit           hold;
        bit           gab;
        bit           exp_found;
        bit           exp_exh;
        logic [31:0]  exp_nonce;
    } vec_t;

    initial begin
        vec_t         vecs[6];
        logic [255:0] tb;
        tb = 256'h00000000_0000abcd_ef012345_6789abcd_ef012345_6789abcd_ef012345_6789abcd;
        vecs[0] = '{32'h10, {256{1'b1}}, 256'h0, 256'h0, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
        vecs[1] = '{32'h5, 256'h0000FFFF << 224, 256'h0100, 256'h0100_0000, 2, 2, 1'b0, 1'b0,
                    1'b1, 1'b0, 32'h6};
        vecs[2] = '{32'd100, tb, rev(tb + 256'd1), rev(tb), 2, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd101};
        vecs[3] = '{NONCE_MAX - 32'd1, 256'h0, {256{1'b1}}, {256{1'b1}}, 2, 2, 1'b0, 1'b0,
                    1'b0, 1'b1, NONCE_MAX};
        vecs[4] = '{32'hABCD, {256{1'b1}}, 256'hDEADBEEF_01234567_89ABCDEF_CAFEF00D_11223344_55667788_99AABBCC_DDEEFF00,
                    256'h0, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hABCD};
        vecs[5] = '{32'h1234, 256'h1 << 200, {256{1'b1}}, 256'h0, 2, 1, 1'b0, 1'b1,
                    1'b1, 1'b0, 32'h1235};

        // Reset state.
        tick(); tick(); tick();
        chk("reset_outputs", {next_req, busy, found, exhausted, done, mem_acc_write_en}, 0);
        chk("reset_nonce", nonce_out, 0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", {busy, mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data}, 0);

        // A digest while idle must be ignored.
        hash_valid = 1'b1; hash = 256'h0;
        tick();
        hash_valid = 1'b0;
        tick();
        chk("idle_hash_ignored", {busy, next_req, mem_acc_write_en, found}, 0);

        for (int v = 0; v < 6; v++) begin
            hq.delete();
            hq.push_back(vecs[v].h0);
            if (vecs[v].nh > 1) hq.push_back(vecs[v].h1);
            run_job(vecs[v].ns, vecs[v].tgt, vecs[v].dly, vecs[v].hold, vecs[v].gab, -1);
            chk("vec_found", found, vecs[v].exp_found);
            chk("vec_exhausted", exhausted, vecs[v].exp_exh);
            chk("vec_nonce", nonce_out, vecs[v].exp_nonce);
        end

        // Reset while word 4 is on the bus, then a clean restart.
        hq.delete(); hq.push_back(256'h0);
        run_job(32'h77, {256{1'b1}}, 1, 1'b0, 1'b0, 4);
        tick();
        chk("rst_stays_idle", {busy, mem_acc_write_en}, 0);
        hq.delete(); hq.push_back(256'h5);
        run_job(32'h78, {256{1'b1}}, 2, 1'b0, 1'b0, -1);

        // Randomized jobs.
        for (int r = 0; r < 20; r++) begin
            logic [31:0]  ns;
            logic [31:0]  cur;
            logic [255:0] tgt;
            logic [255:0] h;
            int           dly;
            bit           hold;
            ns  = ($urandom_range(0, 3) == 0) ? NONCE_MAX - 32'($urandom_range(0, 3)) : $urandom;
            tgt = rnd256() >> $urandom_range(0, 96);
            hq.delete();
            cur = ns;
            for (int i = 0; i < 6; i++) begin
                h = (i == 5) ? rev(tgt) : rnd256();
                hq.push_back(h);
                if (model_hit(h, tgt) || cur == NONCE_MAX) break;
                cur = cur + 32'd1;
            end
            hold = ($urandom_range(0, 3) == 0);
            dly  = hold ? 0 : $urandom_range(0, 3);
            run_job(ns, tgt, dly, hold, (dly > 0) && ($urandom_range(0, 1) == 1), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
